ctrl_grid_n: RTL and testbench

//  Parametrised successor to our fixed-size sequential control benchmarks: NCH request channels

---
 rtl/ctrl_grid_pkg.sv | 24 ++
 rtl/ctrl_grid_chan.sv | 103 ++++++++++
 rtl/ctrl_grid_n.sv | 92 +++++++++
 tb/tb_ctrl_grid_n.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/ctrl_grid_pkg.sv
// ctrl_grid_pkg
//   Shared definitions for the ctrl_grid_n channel/arbiter slice:
//   - chan_state_e : per-channel FSM encoding (2 bits)
//   - NCH_MIN/NCH_MAX : supported channel-count range
//   - CW_MAX : widest hold counter the load helper handles
//   - hold_load() : counter load value, max(hold, 1)
package ctrl_grid_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RUN  = 2'd2
   } chan_state_e;

   localparam int NCH_MIN = 2;
   localparam int NCH_MAX = 16;
   localparam int CW_MAX  = 16;

   // A zero hold still has to give the grantee one cycle on the resource.
   function automatic logic [CW_MAX-1:0] hold_load(input logic [CW_MAX-1:0] hold);
      return (hold == '0) ? CW_MAX'(1) : hold;
   endfunction

endpackage

// File: rtl/ctrl_grid_chan.sv
// ctrl_grid_chan
//   One request channel: IDLE/WAIT/RUN FSM, hold counter, DONE pulse and
//   sticky overrun flag.
//   Ports:
//     clk_i, rst_ni   clock, asynchronous active-low reset
//     en_i            global advance enable
//     req_i, clr_i    request / abort for this channel
//     win_i           arbiter grant for this channel (only honoured in WAIT)
//     hold_i          hold length loaded on grant
//     wait_o, run_o   state decodes
//     last_o          in RUN with counter at 1 (completes on next EN edge)
//     done_o, ovr_o   registered completion pulse, sticky overrun
module ctrl_grid_chan
   import ctrl_grid_pkg::*;
#(
   parameter int CW = 4
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          en_i,
   input  logic          req_i,
   input  logic          clr_i,
   input  logic          win_i,
   input  logic [CW-1:0] hold_i,
   output logic          wait_o,
   output logic          run_o,
   output logic          last_o,
   output logic          done_o,
   output logic          ovr_o
);

   chan_state_e   state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          done_q, done_d;
   logic          ovr_q, ovr_d;
   logic          last;

   assign last = (state_q == ST_RUN) && (cnt_q == CW'(1));

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      ovr_d   = ovr_q;
      if (clr_i) begin
         // Abort beats everything, including a completion on this edge.
         state_d = ST_IDLE;
         cnt_d   = '0;
         ovr_d   = 1'b0;
      end else if (en_i) begin
         if (req_i && (state_q != ST_IDLE)) begin
            ovr_d = 1'b1;
         end
         case (state_q)
            ST_IDLE: begin
               if (req_i) begin
                  state_d = ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (win_i) begin
                  state_d = ST_RUN;
                  cnt_d   = CW'(hold_load(CW_MAX'(hold_i)));
               end
            end
            ST_RUN: begin
               if (last) begin
                  state_d = ST_IDLE;
                  cnt_d   = '0;
                  done_d  = 1'b1;
               end else begin
                  cnt_d = cnt_q - CW'(1);
               end
            end
            default: begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         done_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
         ovr_q   <= ovr_d;
      end
   end

   assign wait_o = (state_q == ST_WAIT);
   assign run_o  = (state_q == ST_RUN);
   assign last_o = last;
   assign done_o = done_q;
   assign ovr_o  = ovr_q;

endmodule

// File: rtl/ctrl_grid_n.sv
// ctrl_grid_n
//   NCH request channels sharing one resource through a round-robin arbiter.
//   Ports:
//     CK, RN     clock, asynchronous active-low reset
//     EN         global advance enable
//     REQ, CLR   per-channel request / abort (NCH bits)
//     CFG_HOLD   grant hold length, loaded on grant (CW bits)
//     GNT        channel is in RUN (one-hot or zero)
//     BUSY       channel is in WAIT or RUN
//     DONE       one-cycle completion pulse
//     OVR        sticky: request seen while channel not idle
//   All outputs decode channel flops only; no input reaches an output
//   combinationally.
module ctrl_grid_n
   import ctrl_grid_pkg::*;
#(
   parameter int NCH = 4,
   parameter int CW  = 4
) (
   input  logic           CK,
   input  logic           RN,
   input  logic           EN,
   input  logic [NCH-1:0] REQ,
   input  logic [NCH-1:0] CLR,
   input  logic [CW-1:0]  CFG_HOLD,
   output logic [NCH-1:0] GNT,
   output logic [NCH-1:0] BUSY,
   output logic [NCH-1:0] DONE,
   output logic [NCH-1:0] OVR
);

   // NCH >= NCH_MIN keeps the pointer at least one bit wide.
   localparam int PW = $clog2(NCH);

   logic [NCH-1:0] wait_v, run_v, last_v, done_v, ovr_v, win_v;
   logic [PW-1:0]  ptr_q, ptr_d;
   logic           free;
   logic           found;
   int             idx;

   for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
      ctrl_grid_chan #(.CW(CW)) u_chan (
         .clk_i  (CK),
         .rst_ni (RN),
         .en_i   (EN),
         .req_i  (REQ[gi]),
         .clr_i  (CLR[gi]),
         .win_i  (win_v[gi]),
         .hold_i (CFG_HOLD),
         .wait_o (wait_v[gi]),
         .run_o  (run_v[gi]),
         .last_o (last_v[gi]),
         .done_o (done_v[gi]),
         .ovr_o  (ovr_v[gi])
      );
   end

   always_comb begin
      // The resource can be handed over on this edge if nobody holds it, or
      // the holder finishes now. A holder being aborted does not count: the
      // next grant waits one edge.
      free  = EN && ((run_v == '0) || ((last_v & ~CLR) != '0));
      win_v = '0;
      ptr_d = ptr_q;
      found = 1'b0;
      idx   = 0;
      if (free) begin
         for (int k = 0; k < NCH; k++) begin
            idx = (int'(ptr_q) + k) % NCH;
            if (!found && wait_v[idx] && !CLR[idx]) begin
               found      = 1'b1;
               win_v[idx] = 1'b1;
               ptr_d      = PW'((idx + 1) % NCH);
            end
         end
      end
   end

   always_ff @(posedge CK or negedge RN) begin
      if (!RN) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   assign GNT  = run_v;
   assign BUSY = wait_v | run_v;
   assign DONE = done_v;
   assign OVR  = ovr_v;

endmodule

// File: tb/tb_ctrl_grid_n.sv
module tb_ctrl_grid_n;

   logic       CK = 1'b0;
   logic       RN;
   logic       EN;
   logic [3:0] REQ, CLR, CFG_HOLD;
   logic [3:0] GNT, BUSY, DONE, OVR;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic       en;
      logic [3:0] req;
      logic [3:0] clr;
      logic [3:0] hold;
      logic [3:0] gnt;
      logic [3:0] busy;
      logic [3:0] done;
      logic [3:0] ovr;
   } vec_t;

   vec_t tbl[$];

   ctrl_grid_n #(.NCH(4), .CW(4)) dut (
      .CK       (CK),
      .RN       (RN),
      .EN       (EN),
      .REQ      (REQ),
      .CLR      (CLR),
      .CFG_HOLD (CFG_HOLD),
      .GNT      (GNT),
      .BUSY     (BUSY),
      .DONE     (DONE),
      .OVR      (OVR)
   );

   always #5 CK = ~CK;

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string name, input int n, input logic [3:0] got, input logic [3:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s[%0d] got=%b exp=%b", name, n, got, exp);
      end
   endtask

   // Drive inputs away from the edge, take one edge, sample 1 time unit later.
   task automatic drive(input logic en, input logic [3:0] req, input logic [3:0] clr, input logic [3:0] hold);
      EN = en; REQ = req; CLR = clr; CFG_HOLD = hold;
      @(posedge CK);
      #1;
   endtask

   task automatic add(input logic en, input logic [3:0] req, input logic [3:0] clr, input logic [3:0] hold,
                      input logic [3:0] gnt, input logic [3:0] busy, input logic [3:0] done, input logic [3:0] ovr);
      vec_t v;
      v.en = en; v.req = req; v.clr = clr; v.hold = hold;
      v.gnt = gnt; v.busy = busy; v.done = done; v.ovr = ovr;
      tbl.push_back(v);
   endtask

   // Request one channel and measure how many cycles GNT stays on it.
   task automatic run_len(input logic [3:0] mask, input logic [3:0] hold, input int exp_len, input string name);
      int len;
      len = 0;
      drive(1'b1, mask, 4'b0000, hold);
      chk({name, "_busy"}, 0, BUSY, mask);
      drive(1'b1, 4'b0000, 4'b0000, hold);
      while (GNT == mask && len < 40) begin
         len++;
         drive(1'b1, 4'b0000, 4'b0000, hold);
      end
      checks++;
      if (len != exp_len) begin
         errors++;
         $display("FAIL %s_len got=%0d exp=%0d", name, len, exp_len);
      end
      $display("run %s hold=%0d gnt_cycles=%0d done=%b", name, hold, len, DONE);
      chk({name, "_done"}, 0, DONE, mask);
      drive(1'b1, 4'b0000, 4'b0000, hold);
      chk({name, "_done_off"}, 0, DONE, 4'b0000);
   endtask

   initial begin
      RN = 1'b1; EN = 1'b0; REQ = '0; CLR = '0; CFG_HOLD = '0;

      //   en  req      clr      hold   | gnt      busy     done     ovr
      // four simultaneous requests, hold 2: ch0..ch3 in order, no bubble
      add(1, 4'b1111, 4'b0000, 4'd2,  4'b0000, 4'b1111, 4'b0000, 4'b0000);
      add(1, 4'b0000, 4'b0000, 4'd2,  4'b0001, 4'b1111, 4'b0000, 4'b0000);
      add(1, 4'b0000, 4'b0000, 4'd2,  4'b0001, 4'b1111, 4'b0000, 4'b0000);
      add(1, 4'b0000, 4'b0000, 4'd2,  4'b0010, 4'b1110, 4'b0001, 4'b0000);
      add(1, 4'b0000, 4'b0000, 4'd2,  4'b0010, 4'b1110, 4'b0000, 4'b0000);
      add(1, 4'b0000, 4'b0000, 4'd2,  4'b0100, 4'b1100, 4'b0010, 4'b0000);
      add(1, 4'b0000, 4'b0000, 4'd2,  4'b0100, 4'b1100, 4'b0000, 4'b0000);
      add(1, 4'b0000, 4'b0000, 4'd2,  4'b1000, 4'b1000, 4'b0100, 4'b0000);
      add(1, 4'b0000, 4'b0000, 4'd2,  4'b1000, 4'b1000, 4'b0000, 4'b0000);
      add(1, 4'b0000, 4'b0000, 4'd2,  4'b0000, 4'b0000, 4'b1000, 4'b0000);
      add(1, 4'b0000, 4'b0000, 4'd2,  4'b0000, 4'b0000, 4'b0000, 4'b0000);
      // hold 0 behaves as hold 1
      add(1, 4'b0001, 4'b0000, 4'd0,  4'b0000, 4'b0001, 4'b0000, 4'b0000);
      add(1, 4'b0000, 4'b0000, 4'd0,  4'b0001, 4'b0001, 4'b0000, 4'b0000);
      add(1, 4'b0000, 4'b0000, 4'd0,  4'b0000, 4'b0000, 4'b0001, 4'b0000);
      add(1, 4'b0000, 4'b0000, 4'd0,  4'b0000, 4'b0000, 4'b0000, 4'b0000);
      // overrun on ch1 during RUN, sticky, cleared by CLR even with EN=0
      add(1, 4'b0010, 4'b0000, 4'd3,  4'b0000, 4'b0010, 4'b0000, 4'b0000);
      add(1, 4'b0000, 4'b0000, 4'd3,  4'b0010, 4'b0010, 4'b0000, 4'b0000);
      add(1, 4'b0010, 4'b0000, 4'd3,  4'b0010, 4'b0010, 4'b0000, 4'b0010);
      add(1, 4'b0000, 4'b0000, 4'd3,  4'b0010, 4'b0010, 4'b0000, 4'b0010);
      add(1, 4'b0000, 4'b0000, 4'd3,  4'b0000, 4'b0000, 4'b0010, 4'b0010);
      add(1, 4'b0000, 4'b0000, 4'd3,  4'b0000, 4'b0000, 4'b0000, 4'b0010);
      add(0, 4'b0000, 4'b0010, 4'd3,  4'b0000, 4'b0000, 4'b0000, 4'b0000);
      // CLR and REQ together: request dropped
      add(1, 4'b0100, 4'b0100, 4'd3,  4'b0000, 4'b0000, 4'b0000, 4'b0000);
      // abort ch0 in RUN with ch3 waiting: ch3 granted one edge later
      add(1, 4'b0001, 4'b0000, 4'd4,  4'b0000, 4'b0001, 4'b0000, 4'b0000);
      add(1, 4'b0000, 4'b0000, 4'd4,  4'b0001, 4'b0001, 4'b0000, 4'b0000);
      add(1, 4'b1000, 4'b0000, 4'd4,  4'b0001, 4'b1001, 4'b0000, 4'b0000);
      add(1, 4'b0000, 4'b0001, 4'd4,  4'b0000, 4'b1000, 4'b0000, 4'b0000);
      add(1, 4'b0000, 4'b0000, 4'd4,  4'b1000, 4'b1000, 4'b0000, 4'b0000);
      add(1, 4'b0000, 4'b0000, 4'd4,  4'b1000, 4'b1000, 4'b0000, 4'b0000);
      add(1, 4'b0000, 4'b0000, 4'd4,  4'b1000, 4'b1000, 4'b0000, 4'b0000);
      add(1, 4'b0000, 4'b0000, 4'd4,  4'b1000, 4'b1000, 4'b0000, 4'b0000);
      // CLR on the completing edge: no DONE
      add(1, 4'b0000, 4'b1000, 4'd4,  4'b0000, 4'b0000, 4'b0000, 4'b0000);
      // EN low for 3 cycles mid-RUN, hold 4: GNT lasts 7 cycles
      add(1, 4'b0001, 4'b0000, 4'd4,  4'b0000, 4'b0001, 4'b0000, 4'b0000);
      add(1, 4'b0000, 4'b0000, 4'd4,  4'b0001, 4'b0001, 4'b0000, 4'b0000);
      add(1, 4'b0000, 4'b0000, 4'd4,  4'b0001, 4'b0001, 4'b0000, 4'b0000);
      add(0, 4'b0000, 4'b0000, 4'd4,  4'b0001, 4'b0001, 4'b0000, 4'b0000);
      add(0, 4'b0011, 4'b0000, 4'd4,  4'b0001, 4'b0001, 4'b0000, 4'b0000);
      add(0, 4'b0000, 4'b0000, 4'd4,  4'b0001, 4'b0001, 4'b0000, 4'b0000);
      add(1, 4'b0000, 4'b0000, 4'd4,  4'b0001, 4'b0001, 4'b0000, 4'b0000);
      add(1, 4'b0000, 4'b0000, 4'd4,  4'b0001, 4'b0001, 4'b0000, 4'b0000);
      add(1, 4'b0000, 4'b0000, 4'd4,  4'b0000, 4'b0000, 4'b0001, 4'b0000);
      add(0, 4'b0000, 4'b0000, 4'd4,  4'b0000, 4'b0000, 4'b0000, 4'b0000);
      // pointer sits at 1: ch1 wins over ch0, then ch0 follows without a bubble
      add(1, 4'b0011, 4'b0000, 4'd1,  4'b0000, 4'b0011, 4'b0000, 4'b0000);
      add(1, 4'b0000, 4'b0000, 4'd1,  4'b0010, 4'b0011, 4'b0000, 4'b0000);
      add(1, 4'b0000, 4'b0000, 4'd1,  4'b0001, 4'b0001, 4'b0010, 4'b0000);
      add(1, 4'b0000, 4'b0000, 4'd1,  4'b0000, 4'b0000, 4'b0001, 4'b0000);

      // reset state
      #2 RN = 1'b0;
      #1;
      chk("rst_gnt", 0, GNT, 4'b0000);
      chk("rst_busy", 0, BUSY, 4'b0000);
      chk("rst_done", 0, DONE, 4'b0000);
      chk("rst_ovr", 0, OVR, 4'b0000);
      @(posedge CK);
      @(posedge CK);
      #1 RN = 1'b1;

      foreach (tbl[n]) begin
         drive(tbl[n].en, tbl[n].req, tbl[n].clr, tbl[n].hold);
         $display("vec %0d en=%b req=%b clr=%b hold=%0d -> gnt=%b busy=%b done=%b ovr=%b",
                  n, tbl[n].en, tbl[n].req, tbl[n].clr, tbl[n].hold, GNT, BUSY, DONE, OVR);
         chk("gnt", n, GNT, tbl[n].gnt);
         chk("busy", n, BUSY, tbl[n].busy);
         chk("done", n, DONE, tbl[n].done);
         chk("ovr", n, OVR, tbl[n].ovr);
      end

      // asynchronous reset in the middle of a hold-5 grant on ch2
      drive(1'b1, 4'b0100, 4'b0000, 4'd5);
      drive(1'b1, 4'b0000, 4'b0000, 4'd5);
      drive(1'b1, 4'b0000, 4'b0000, 4'd5);
      chk("pre_rst_gnt", 0, GNT, 4'b0100);
      #3 RN = 1'b0;
      #1;
      $display("async reset mid-run -> gnt=%b busy=%b done=%b ovr=%b", GNT, BUSY, DONE, OVR);
      chk("arst_gnt", 0, GNT, 4'b0000);
      chk("arst_busy", 0, BUSY, 4'b0000);
      chk("arst_done", 0, DONE, 4'b0000);
      chk("arst_ovr", 0, OVR, 4'b0000);
      @(posedge CK);
      #1;
      chk("arst_hold_gnt", 0, GNT, 4'b0000);
      RN = 1'b1;

      run_len(4'b0100, 4'd5, 5, "t1_ch2_hold5");
      run_len(4'b0010, 4'd15, 15, "t3_ch1_hold15");
      run_len(4'b0001, 4'd0, 1, "t3_ch0_hold0");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
